// File: rtl/vga_scan_timing.sv
// vga_scan_timing: 640x480 VGA raster timing with a per-visible-pixel enable strobe.
// All outputs are registered on the pixel slot edge, so hcount/vcount/enable describe the same pixel.
module vga_scan_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       pix_tick,
    output logic       enable,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [9:0]    h, v;
    logic          slot;

    assign slot = run && div == D_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            pix_tick    <= 1'b0;
            enable      <= 1'b0;
            frame_start <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
        end else begin
            pix_tick    <= slot;
            enable      <= slot && h < HA && v < VA;
            frame_start <= slot && h == '0 && v == '0;
            if (run)
                div <= slot ? '0 : div + 1'b1;
            // Present the current position, then step to the next one in raster order.
            if (slot) begin
                hcount <= h;
                vcount <= v;
                hsync  <= !(h >= HS0 && h < HS1);
                vsync  <= !(v >= VS0 && v < VS1);
                h      <= h == H_LAST ? '0 : h + 10'd1;
                if (h == H_LAST)
                    v <= v == V_LAST ? '0 : v + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: checks a full-size instance and a shrunken CLK_DIV=4 instance against an arithmetic raster model.
module tb_vga_scan_timing;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0;
    logic pt_a, en_a, fs_a, hs_a, vs_a, pt_b, en_b, fs_b, hs_b, vs_b;
    logic [9:0] hc_a, vc_a, hc_b, vc_b;
    int total = 0, bad = 0, n = 0;
    bit ran;

    always #5 clk = ~clk;

    vga_scan_timing dut_a (
        .clk(clk), .rst(rst), .run(run), .pix_tick(pt_a), .enable(en_a), .hcount(hc_a),
        .vcount(vc_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    vga_scan_timing #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .rst(rst), .run(run), .pix_tick(pt_b), .enable(en_b), .hcount(hc_b),
        .vcount(vc_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    function automatic logic [24:0] vec(input bit p, e, f, input int h, v, input bit hs, vs);
        return {p, e, f, 10'(h), 10'(v), hs, vs};
    endfunction

    // k = run-high edges since reset; every cd-th one presents raster pixel (k/cd - 1) mod frame size.
    function automatic logic [24:0] model(input int k, input bit ok, input int cd, ha, hfp, hsw, hbp,
                                          va, vfp, vsw, vbp);
        int ht, vt, p, h, v;
        bit fire;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        fire = ok && k > 0 && k % cd == 0;
        if (k < cd) return vec(0, 0, 0, 0, 0, 1, 1);
        p = (k / cd - 1) % (ht * vt);
        h = p % ht;
        v = p / ht;
        return vec(fire, fire && h < ha && v < va, fire && p == 0, h, v,
                   !(h >= ha + hfp && h < ha + hfp + hsw), !(v >= va + vfp && v < va + vfp + vsw));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick(input bit r, input bit rn);
        rst = r;
        run = rn;
        @(posedge clk);
        n = r ? 0 : n + int'(rn);
        ran = !r && rn;
        #1;
        check("model_a", {pt_a, en_a, fs_a, hc_a, vc_a, hs_a, vs_a},
              model(n, ran, 2, 640, 16, 96, 48, 480, 10, 2, 33));
        check("model_b", {pt_b, en_b, fs_b, hc_b, vc_b, hs_b, vs_b},
              model(n, ran, 4, 8, 2, 3, 2, 6, 1, 2, 1));
    endtask

    typedef struct {
        bit r;
        bit rn;
        int cyc;
        logic [24:0] want;
    } row_t;

    row_t rows[13];
    int cnt_pt, cnt_en, cnt_fs, cnt_vs, cnt_hs, addr, last;
    bit found;

    initial begin
        rows[0]  = '{1, 1, 3,    vec(0, 0, 0, 0,   0, 1, 1)};
        rows[1]  = '{0, 1, 1,    vec(0, 0, 0, 0,   0, 1, 1)};
        rows[2]  = '{0, 1, 1,    vec(1, 1, 1, 0,   0, 1, 1)};
        rows[3]  = '{0, 1, 200,  vec(1, 1, 0, 100, 0, 1, 1)};
        rows[4]  = '{0, 0, 7,    vec(0, 0, 0, 100, 0, 1, 1)};
        rows[5]  = '{0, 1, 2,    vec(1, 1, 0, 101, 0, 1, 1)};
        rows[6]  = '{0, 1, 1108, vec(1, 0, 0, 655, 0, 1, 1)};
        rows[7]  = '{0, 1, 2,    vec(1, 0, 0, 656, 0, 0, 1)};
        rows[8]  = '{0, 1, 190,  vec(1, 0, 0, 751, 0, 0, 1)};
        rows[9]  = '{0, 1, 2,    vec(1, 0, 0, 752, 0, 1, 1)};
        rows[10] = '{0, 1, 94,   vec(1, 0, 0, 799, 0, 1, 1)};
        rows[11] = '{0, 1, 2,    vec(1, 1, 0, 0,   1, 1, 1)};
        rows[12] = '{1, 1, 1,    vec(0, 0, 0, 0,   0, 1, 1)};
        foreach (rows[i]) begin
            for (int c = 0; c < rows[i].cyc; c++) tick(rows[i].r, rows[i].rn);
            check($sformatf("row%0d", i), {pt_a, en_a, fs_a, hc_a, vc_a, hs_a, vs_a}, rows[i].want);
        end

        // One full-size line: 800 slots, 640 visible, 96 in hsync.
        cnt_pt = 0; cnt_en = 0; cnt_hs = 0;
        for (int i = 0; i < 1600; i++) begin
            tick(0, 1);
            cnt_pt += int'(pt_a);
            cnt_en += int'(en_a);
            cnt_hs += int'(pt_a && !hs_a);
        end
        check("line_ticks", cnt_pt, 800);
        check("line_enables", cnt_en, 640);
        check("line_hsync", cnt_hs, 96);

        // One shrunken frame plus the wrap slot, with a downstream address counter.
        tick(1, 1);
        cnt_pt = 0; cnt_en = 0; cnt_fs = 0; cnt_vs = 0; addr = 0; last = -1;
        for (int i = 0; i < 604; i++) begin
            tick(0, 1);
            if (fs_b) check("addr_wrap", addr, 0);
            if (en_b) addr = addr == 47 ? 0 : addr + 1;
            if (pt_b) begin
                if (last >= 0) check("tick_period", i - last, 4);
                last = i;
            end
            if (i < 600) begin
                cnt_pt += int'(pt_b);
                cnt_en += int'(en_b);
                cnt_fs += int'(fs_b);
                cnt_vs += int'(pt_b && !vs_b);
            end
        end
        check("frame_ticks", cnt_pt, 150);
        check("frame_enables", cnt_en, 48);
        check("frame_starts", cnt_fs, 1);
        check("frame_vsync", cnt_vs, 30);
        check("frame_wrap", {pt_b, en_b, fs_b, hc_b, vc_b, hs_b, vs_b}, vec(1, 1, 1, 0, 0, 1, 1));

        // Mid-frame reset restarts at (0,0).
        found = 0;
        for (int i = 0; i < 700 && !found; i++) begin
            tick(0, 1);
            found = pt_b && hc_b == 10'd7 && vc_b == 10'd5;
        end
        check("find_mid", 32'(found), 1);
        tick(1, 1);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1);
            if (pt_b) break;
        end
        check("mid_reset", {pt_b, en_b, fs_b, hc_b, vc_b, hs_b, vs_b}, vec(1, 1, 1, 0, 0, 1, 1));

        // Random run gaps and occasional resets against the model.
        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
